// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling datapath.
// Sample widths, window slice indices and the signed-max selector.
package pool_pkg;

    localparam int INT_BITS  = 9;
    localparam int FRAC_BITS = 4;
    localparam int DATA_W    = INT_BITS + FRAC_BITS;
    localparam int WIN_W     = 4 * DATA_W;

    localparam int TL_IDX = 0;
    localparam int TR_IDX = 1;
    localparam int BL_IDX = 2;
    localparam int BR_IDX = 3;

    // Operands are sign-extended to this width so any sample width can share it.
    localparam int MAX_W = 32;

    function automatic logic a_is_max(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b
    );
        return a >= b;
    endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous show-ahead FIFO holding pooled results and their last tags.
// Head is visible combinationally; push and pop may occur in the same cycle.
module pool_out_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             pop_en;
    logic             push_en;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_en  = i_pop & ~o_empty;
    assign push_en = i_push & (~o_full | pop_en);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_en) wr_d = wr_q + 1'b1;
        if (pop_en)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_en) mem_q[wr_q[AW-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/pool_max_reader.sv
// Stride-2 decimation of the 2x2 window stream, signed max in two stages,
// and an output FIFO with frame-last tagging toward the next layer.
module pool_max_reader
    import pool_pkg::*;
#(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_WIDTH        = 512,
    parameter int IMG_HEIGHT       = 512,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic [4*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]      i_window_data,
    input  logic                                              i_window_valid,
    output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]          o_pool_data,
    output logic                                              o_pool_valid,
    input  logic                                              i_pool_ready,
    output logic                                              o_pool_last,
    output logic                                              o_frame_done,
    output logic                                              o_overflow
);

    localparam int DW = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    function automatic logic signed [MAX_W-1:0] sx(input logic [DW-1:0] v);
        return {{(MAX_W-DW){v[DW-1]}}, v};
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] tl, tr, bl, br;
    logic          keep, last;

    logic          s1_valid_q, s1_last_q;
    logic [DW-1:0] m0_q, m0_d, m1_q, m1_d;
    logic          s2_valid_q, s2_last_q;
    logic [DW-1:0] mx_q, mx_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full, fifo_empty, pop, push;
    logic [DW:0]   fifo_head;

    assign tl = i_window_data[TL_IDX*DW +: DW];
    assign tr = i_window_data[TR_IDX*DW +: DW];
    assign bl = i_window_data[BL_IDX*DW +: DW];
    assign br = i_window_data[BR_IDX*DW +: DW];

    assign keep = i_window_valid & ~col_q[0] & ~row_q[0];
    assign last = (row_q == RW'(IMG_HEIGHT-2)) && (col_q == CW'(IMG_WIDTH-2));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_window_valid) begin
            if (col_q == CW'(IMG_WIDTH-1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_HEIGHT-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        m0_d = a_is_max(sx(tl), sx(tr)) ? tl : tr;
        m1_d = a_is_max(sx(bl), sx(br)) ? bl : br;
        mx_d = a_is_max(sx(m0_q), sx(m1_q)) ? m0_q : m1_q;
    end

    assign pop  = ~fifo_empty & i_pool_ready;
    assign push = s2_valid_q;
    // A full FIFO still takes the write when the head leaves in the same cycle.
    assign ovf_d = ovf_q | (s2_valid_q & fifo_full & ~i_pool_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            m0_q       <= '0;
            m1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            mx_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= keep;
            s1_last_q  <= keep & last;
            m0_q       <= m0_d;
            m1_q       <= m1_d;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q & s1_last_q;
            mx_q       <= mx_d;
            ovf_q      <= ovf_d;
        end
    end

    pool_out_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({s2_last_q, mx_q}),
        .i_pop   (pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_pool_valid = ~fifo_empty;
    assign o_pool_data  = fifo_head[DW-1:0];
    assign o_pool_last  = fifo_head[DW];
    assign o_frame_done = s2_valid_q & s2_last_q;
    assign o_overflow   = ovf_q;

endmodule
